// File: rtl/fifo_level_pkg.sv
// Shared sizing helpers for the level-tracking FIFO: pointer/level widths and parameter sanity checks.
package fifo_level_pkg;

  localparam int FIFO_MAX_DEPTH = 65536;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of level/peak outputs: must represent 0..DEPTH inclusive.
  function automatic int fifo_level_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous (combinational) read.
// Kept separate so a registered-read block RAM can be swapped in later.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_level.sv
// Single-clock show-ahead FIFO with occupancy, almost flags, high-water mark and sticky errors.
// Zero-latency read of the head word; a push on a full FIFO is dropped unless a pop frees the slot.
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 256,
  parameter int AFULL_LEVEL  = 192,
  parameter int AEMPTY_LEVEL = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               write_data,
  input  logic                           write_strobe,
  output logic                           full,
  output logic                           almost_full,
  output logic [WIDTH-1:0]               read_data,
  input  logic                           read_strobe,
  output logic                           data_available,
  output logic                           almost_empty,
  output logic [fifo_level_w(DEPTH)-1:0] level,
  output logic [fifo_level_w(DEPTH)-1:0] peak_level,
  output logic                           overflow,
  output logic                           underflow,
  input  logic                           clear_errors
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] AFULL_L  = AFULL_LEVEL[AW:0];
  localparam logic [AW:0] AEMPTY_L = AEMPTY_LEVEL[AW:0];
  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

  if (DEPTH < 2 || DEPTH > FIFO_MAX_DEPTH || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_level: DEPTH must be a power of two in 2..65536");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("fifo_level: AFULL_LEVEL must be in 1..DEPTH");
  end
  if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_level: AEMPTY_LEVEL must be in 0..DEPTH-1");
  end

  logic [AW:0] r_wptr, r_rptr, r_level, r_peak;
  logic        r_overflow, r_underflow;

  logic        w_full, w_empty, w_push_acc, w_pop_acc;
  logic [AW:0] w_level_nxt, w_peak_nxt;

  // Extra MSB on each pointer distinguishes full from empty when the low bits match.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  assign w_pop_acc  = read_strobe && !w_empty;
  assign w_push_acc = write_strobe && (!w_full || w_pop_acc);

  assign w_level_nxt = r_level + {{AW{1'b0}}, w_push_acc} - {{AW{1'b0}}, w_pop_acc};
  assign w_peak_nxt  = (w_level_nxt > r_peak) ? w_level_nxt : r_peak;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_peak      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) r_wptr <= r_wptr + ONE;
      if (w_pop_acc)  r_rptr <= r_rptr + ONE;
      r_level <= w_level_nxt;
      // A clear wins over an error raised in the same cycle.
      if (clear_errors) begin
        r_peak      <= w_level_nxt;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        r_peak <= w_peak_nxt;
        if (write_strobe && !w_push_acc) r_overflow  <= 1'b1;
        if (read_strobe && !w_pop_acc)   r_underflow <= 1'b1;
      end
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push_acc),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (write_data),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (read_data)
  );

  assign full           = w_full;
  assign data_available = !w_empty;
  assign almost_full    = (r_level >= AFULL_L);
  assign almost_empty   = (r_level <= AEMPTY_L);
  assign level          = r_level;
  assign peak_level     = r_peak;
  assign overflow       = r_overflow;
  assign underflow      = r_underflow;

endmodule
